// File: rtl/l2_mem_adapter_if.sv
// Cache-side and memory-side signal bundle
// for the L2 line-to-burst adapter.
interface l2_mem_adapter_if #(
  parameter int s_line = 256,
  parameter int s_beat = 64
) ();

  logic              line_read;
  logic              line_write;
  logic [31:0]       line_address;
  logic [s_line-1:0] line_wdata;
  logic [s_line-1:0] line_rdata;
  logic              line_resp;

  logic              burst_read;
  logic              burst_write;
  logic [31:0]       burst_address;
  logic [s_beat-1:0] burst_wdata;
  logic [s_beat-1:0] burst_rdata;
  logic              burst_resp;

  modport slave (
    input  line_read,
    input  line_write,
    input  line_address,
    input  line_wdata,
    output line_rdata,
    output line_resp,
    output burst_read,
    output burst_write,
    output burst_address,
    output burst_wdata,
    input  burst_rdata,
    input  burst_resp
  );

  modport master (
    output line_read,
    output line_write,
    output line_address,
    output line_wdata,
    input  line_rdata,
    input  line_resp,
    input  burst_read,
    input  burst_write,
    input  burst_address,
    input  burst_wdata,
    output burst_rdata,
    output burst_resp
  );

endinterface

// File: rtl/l2_mem_adapter.sv
// Converts one cache line request into a
// four-beat memory burst, read or write.
module l2_mem_adapter #(
  parameter int s_line = 256,
  parameter int s_beat = 64
) (
  input logic clk,
  input logic reset,
  l2_mem_adapter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [1:0]        beat_q;
  logic [1:0]        beat_d;
  logic [31:0]       addr_q;
  logic [31:0]       addr_d;
  logic [s_line-1:0] wbuf_q;
  logic [s_line-1:0] wbuf_d;
  logic [s_line-1:0] rdata_q;
  logic [s_line-1:0] rdata_d;

  // Registered state; reset aborts any burst in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      wbuf_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      wbuf_q  <= wbuf_d;
      rdata_q <= rdata_d;
    end
  end

  // Next state: latch request in IDLE, count beats on resp.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    wbuf_d  = wbuf_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.line_write || bus.line_read) begin
          state_d = bus.line_write ? WRITE : READ;
          addr_d  = bus.line_address & ~32'h1f;
          wbuf_d  = bus.line_wdata;
          beat_d  = '0;
        end
      end
      READ: begin
        if (bus.burst_resp) begin
          rdata_d[s_beat*beat_q +: s_beat] = bus.burst_rdata;
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = DONE;
        end
      end
      WRITE: begin
        if (bus.burst_resp) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.burst_read    = (state_q == READ);
  assign bus.burst_write   = (state_q == WRITE);
  assign bus.line_resp     = (state_q == DONE);
  assign bus.burst_address = addr_q;
  assign bus.line_rdata    = rdata_q;
  assign bus.burst_wdata   = (state_q == WRITE)
                           ? wbuf_q[s_beat*beat_q +: s_beat]
                           : '0;

endmodule

// File: tb/tb_l2_mem_adapter.sv
// Directed bench for l2_mem_adapter with a
// transaction-level reference model.
module tb_l2_mem_adapter;

  localparam int SL = 256;
  localparam int SB = 64;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  l2_mem_adapter_if #(.s_line(SL), .s_beat(SB)) bus ();

  l2_mem_adapter #(.s_line(SL), .s_beat(SB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name,
                       input logic [SL-1:0] act,
                       input logic [SL-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a line transaction is either idle,
  // moving beats (count 0..3), or reporting completion.
  bit          m_busy;
  bit          m_wr;
  int          m_beats;
  bit          m_done;
  logic [31:0] m_addr;
  logic [SL-1:0] m_line;
  logic [SL-1:0] m_rdata;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_busy  = 1'b0;
      m_wr    = 1'b0;
      m_beats = 0;
      m_done  = 1'b0;
      m_addr  = '0;
      m_line  = '0;
      m_rdata = '0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_busy) begin
      if (bus.burst_resp) begin
        if (!m_wr) m_rdata[SB*m_beats +: SB] = bus.burst_rdata;
        m_beats++;
        if (m_beats == 4) begin
          m_busy  = 1'b0;
          m_done  = 1'b1;
          m_beats = 0;
        end
      end
    end else if (bus.line_write || bus.line_read) begin
      m_busy  = 1'b1;
      m_wr    = bus.line_write;
      m_beats = 0;
      m_addr  = {bus.line_address[31:5], 5'b0};
      m_line  = bus.line_wdata;
    end
    chk_en = 1'b1;
  end

  // Compare DUT outputs with the model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("burst_read", bus.burst_read, m_busy && !m_wr);
      check("burst_write", bus.burst_write, m_busy && m_wr);
      check("line_resp", bus.line_resp, m_done);
      check("burst_address", bus.burst_address, m_addr);
      check("line_rdata", bus.line_rdata, m_rdata);
      if (m_busy && m_wr)
        check("burst_wdata", bus.burst_wdata,
              m_line[SB*m_beats +: SB]);
    end
  end

  // Event monitors used by the literal expectations.
  int          resp_count = 0;
  int          resp_cyc = 0;
  int          bw_cnt = 0;
  int          br_cnt = 0;
  int          widx = 0;
  logic [SB-1:0] wcap [4];

  always @(negedge clk) begin
    if (bus.line_resp) begin
      resp_count++;
      resp_cyc = cyc;
    end
    if (bus.burst_write) bw_cnt++;
    if (bus.burst_read) br_cnt++;
    if (bus.burst_write && bus.burst_resp && widx < 4) begin
      wcap[widx] = bus.burst_wdata;
      widx++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SB-1:0] beat(input logic [SB-1:0] base,
                                         input int k);
    logic [7:0] lo;
    lo = 8'(k * 17);
    return {base[SB-1:8], lo};
  endfunction

  int          req_cyc;
  logic [SB-1:0] d [4];
  logic [SL-1:0] exp_line;

  initial begin
    reset = 1'b1;
    bus.line_read = 1'b0;
    bus.line_write = 1'b0;
    bus.line_address = '0;
    bus.line_wdata = '0;
    bus.burst_rdata = '0;
    bus.burst_resp = 1'b0;
    tick();
    tick();
    check("rst_burst_read", bus.burst_read, 0);
    check("rst_burst_write", bus.burst_write, 0);
    check("rst_line_resp", bus.line_resp, 0);
    check("rst_addr", bus.burst_address, 0);
    check("rst_wdata", bus.burst_wdata, 0);
    check("rst_rdata", bus.line_rdata, 0);
    reset = 1'b0;
    tick();

    // Spurious resp while idle.
    bus.burst_resp = 1'b1;
    bus.burst_rdata = 64'hdead_beef_dead_beef;
    tick();
    tick();
    bus.burst_resp = 1'b0;
    check("idle_spur_read", bus.burst_read, 0);
    check("idle_spur_rdata", bus.line_rdata, 0);

    // Read burst, stale address mid-burst, resp during DONE.
    resp_count = 0;
    bus.line_read = 1'b1;
    bus.line_address = 32'h1234_5678;
    req_cyc = cyc;
    tick();
    bus.line_read = 1'b0;
    check("rd_first_req", bus.burst_read, 1);
    check("rd_addr", bus.burst_address, 32'h1234_5660);
    for (int k = 0; k < 4; k++) begin
      bus.burst_resp = 1'b1;
      bus.burst_rdata = beat(64'h1111_2222_3333_4400, k);
      if (k == 1) bus.line_address = 32'hdead_beef;
      tick();
      check("rd_addr_hold", bus.burst_address, 32'h1234_5660);
    end
    bus.burst_rdata = 64'hffff_ffff_ffff_ffff;
    check("rd_done_resp", bus.line_resp, 1);
    check("rd_line", bus.line_rdata,
          {64'h1111_2222_3333_4433, 64'h1111_2222_3333_4422,
           64'h1111_2222_3333_4411, 64'h1111_2222_3333_4400});
    tick();
    bus.burst_resp = 1'b0;
    check("rd_back_idle", bus.burst_read, 0);
    tick();
    tick();
    check("rd_latency", resp_cyc - req_cyc + 1, 6);
    check("rd_resp_once", resp_count, 1);

    // Write with priority over read, two wait cycles per beat.
    d[0] = 64'h0a0a_0000_0000_00d0;
    d[1] = 64'h0b0b_1111_1111_11d1;
    d[2] = 64'h0c0c_2222_2222_22d2;
    d[3] = 64'h0d0d_3333_3333_33d3;
    resp_count = 0;
    bus.line_write = 1'b1;
    bus.line_read = 1'b1;
    bus.line_address = 32'h0000_8abc;
    bus.line_wdata = {d[3], d[2], d[1], d[0]};
    tick();
    bus.line_write = 1'b0;
    bus.line_read = 1'b0;
    bus.line_wdata = '1;
    bw_cnt = 0;
    br_cnt = 0;
    widx = 0;
    for (int k = 0; k < 4; k++) begin
      bus.burst_resp = 1'b0;
      tick();
      tick();
      bus.burst_resp = 1'b1;
      tick();
    end
    bus.burst_resp = 1'b0;
    tick();
    tick();
    check("wr_addr", bus.burst_address, 32'h0000_8aa0);
    check("wr_high_cycles", bw_cnt, 12);
    check("wr_no_read", br_cnt, 0);
    check("wr_beats", widx, 4);
    for (int k = 0; k < 4; k++)
      check("wr_beat_data", wcap[k], d[k]);
    check("wr_resp_once", resp_count, 1);

    // Reset after the third read beat, then restart at once.
    resp_count = 0;
    bus.line_read = 1'b1;
    bus.line_address = 32'h0000_1040;
    tick();
    bus.line_read = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.burst_resp = 1'b1;
      bus.burst_rdata = beat(64'h5555_6666_7777_8800, k);
      tick();
    end
    bus.burst_resp = 1'b0;
    reset = 1'b1;
    tick();
    check("ab_burst_read", bus.burst_read, 0);
    check("ab_burst_write", bus.burst_write, 0);
    check("ab_line_resp", bus.line_resp, 0);
    check("ab_addr", bus.burst_address, 0);
    check("ab_wdata", bus.burst_wdata, 0);
    check("ab_rdata", bus.line_rdata, 0);
    reset = 1'b0;
    bus.line_read = 1'b1;
    bus.line_address = 32'hcafe_babf;
    tick();
    bus.line_read = 1'b0;
    check("re_first_req", bus.burst_read, 1);
    for (int k = 0; k < 4; k++) begin
      bus.burst_resp = 1'b0;
      tick();
      bus.burst_resp = 1'b1;
      bus.burst_rdata = beat(64'h9999_aaaa_bbbb_cc00, k);
      tick();
    end
    bus.burst_resp = 1'b0;
    exp_line = {64'h9999_aaaa_bbbb_cc33, 64'h9999_aaaa_bbbb_cc22,
                64'h9999_aaaa_bbbb_cc11, 64'h9999_aaaa_bbbb_cc00};
    check("re_addr", bus.burst_address, 32'hcafe_baa0);
    check("re_done_resp", bus.line_resp, 1);
    check("re_line", bus.line_rdata, exp_line);
    tick();
    tick();
    check("re_rdata_hold", bus.line_rdata, exp_line);
    check("re_resp_once", resp_count, 1);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/l2_mem_adapter.md
L2_MEM_ADAPTER -- requirements
Module: l2_mem_adapter

Interface
REQ-001 SHALL have parameter s_line, default 256, meaning the cache line width in bits.
REQ-002 SHALL have parameter s_beat, default 64, meaning the burst beat width in bits; s_line SHALL equal 4*s_beat.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port line_read, input, 1 bit: the cache requests a line fill.
REQ-006 SHALL have port line_write, input, 1 bit: the cache requests a line writeback.
REQ-007 SHALL have port line_address, input, 32 bits: the line address from the cache.
REQ-008 SHALL have port line_wdata, input, s_line bits: the writeback line.
REQ-009 SHALL have port line_rdata, output, s_line bits: the assembled fill line.
REQ-010 SHALL have port line_resp, output, 1 bit: a one-cycle completion pulse to the cache.
REQ-011 SHALL have port burst_read, output, 1 bit: the memory read burst request.
REQ-012 SHALL have port burst_write, output, 1 bit: the memory write burst request.
REQ-013 SHALL have port burst_address, output, 32 bits: the 32-byte-aligned burst address.
REQ-014 SHALL have port burst_wdata, output, s_beat bits: the current write beat.
REQ-015 SHALL have port burst_rdata, input, s_beat bits: the incoming read beat.
REQ-016 SHALL have port burst_resp, input, 1 bit: memory accepted or delivered one beat this cycle.

Function
REQ-017 SHALL implement the FSM states IDLE, READ, WRITE and DONE, with a 2-bit beat counter.
REQ-018 In IDLE, line_write=1 SHALL transition to WRITE; otherwise line_read=1 SHALL transition to READ, so write has priority when both requests are asserted.
REQ-019 On leaving IDLE, the block SHALL latch {line_address[31:5],5'b0} into burst_address, latch line_wdata into the write buffer, and clear the beat counter.
REQ-020 burst_read SHALL equal 1 exactly while in READ, and burst_write SHALL equal 1 exactly while in WRITE; both SHALL be driven from registered state.
REQ-021 The first burst request SHALL be visible the cycle after the request is sampled in IDLE.
REQ-022 In READ, each cycle with burst_resp=1 SHALL store burst_rdata into line_rdata bits [s_beat*k +: s_beat], where k is the beat count, and then increment k.
REQ-023 In WRITE, burst_wdata SHALL equal write-buffer bits [s_beat*k +: s_beat], and k SHALL increment on each burst_resp=1.
REQ-024 Cycles with burst_resp=0 SHALL hold all state, so memory may insert wait cycles between beats.
REQ-025 A burst_resp on beat k=3 SHALL transition to DONE; the counter SHALL wrap to 0.
REQ-026 In DONE, line_resp SHALL be 1 for exactly one cycle, followed by an unconditional transition to IDLE.
REQ-027 line_resp SHALL be 0 in every other state.
REQ-028 line_rdata SHALL be valid in the DONE cycle and SHALL hold its value until the next READ beat writes it.
REQ-029 burst_resp SHALL be ignored in IDLE and DONE.
REQ-030 Changes to line_read, line_write, line_address and line_wdata SHALL be ignored outside IDLE.
REQ-031 Minimum latency from request sampled to line_resp SHALL be 6 cycles: 1 cycle to enter READ/WRITE, 4 beats, then DONE.

Reset
REQ-032 While reset=1 at a clock edge, state SHALL become IDLE and the beat counter 0.
REQ-033 While reset=1 at a clock edge, line_resp, burst_read and burst_write SHALL become 0.
REQ-034 While reset=1 at a clock edge, burst_address, burst_wdata and line_rdata SHALL become 0.
REQ-035 A reset during READ, WRITE or DONE SHALL abort the burst, with no line_resp pulse issued for it.
REQ-036 After reset deasserts, the block SHALL accept a new request in IDLE on the following cycle.

Verification
REQ-037 Read test: line_read=1, line_address=0x1234_5678, burst_resp high for 4 consecutive cycles with beats 0x..00, 0x..11, 0x..22, 0x..33 -> burst_address=0x1234_5660; line_rdata = {beat3,beat2,beat1,beat0}; line_resp pulses once, 6 cycles after the request is sampled.
REQ-038 Write test: line_write=1 with line_wdata={D3,D2,D1,D0}, memory inserting 2 wait cycles before each resp -> burst_wdata presents D0, D1, D2, D3 in order; burst_write stays high 12 cycles; line_resp pulses once.
REQ-039 Priority test: line_read=1 and line_write=1 in the same IDLE cycle -> WRITE is entered and burst_read stays 0 throughout.
REQ-040 Spurious-resp test: burst_resp=1 while IDLE, and again during DONE -> no state change and no extra line_resp.
REQ-041 Reset test: reset asserted after beat 2 of a read -> all outputs become 0 the next cycle and no line_resp appears; a subsequent read completes correctly with the counter starting at beat 0.
REQ-042 Stale-input test: line_address changed mid-burst -> burst_address stays at the latched value until DONE.
